// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl: WB pipeline register control (run/stall/flush) with retire and stall counters.
module wb_stage_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem2_valid,
  input  logic        mem2_exception,
  input  logic        mem2_dcache_busy,
  input  logic        ext_hold,
  output logic        wb_wr,
  output logic        wb_flush,
  output logic        mem2_stall,
  output logic        redirect,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  localparam logic [3:0] LOAD = 4'(FLUSH_CYCLES - 1);
  state_t state;
  logic [3:0] cnt;
  logic redir_q;
  logic exc;
  always_comb begin
    exc = state == RUN && mem2_valid && mem2_exception;
    wb_flush = !resetn || exc || state == FLUSH;
    wb_wr = resetn && ((state == RUN && !exc && !mem2_dcache_busy && !ext_hold) ||
                       (state == STALL && !mem2_dcache_busy));
    mem2_stall = resetn && ((state == RUN && !exc && (mem2_dcache_busy || ext_hold)) ||
                            (state == STALL && mem2_dcache_busy));
    // with a single flush cycle, back-to-back acceptances must not merge into a two-cycle pulse
    redirect = resetn && exc && !redir_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      cnt <= '0;
      redir_q <= 1'b0;
      retire_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      redir_q <= redirect;
      if (wb_wr && mem2_valid && !mem2_exception) retire_cnt <= retire_cnt + 32'd1;
      if (state == STALL) stall_cnt <= stall_cnt + 32'd1;
      case (state)
        RUN: begin
          if (exc) begin
            state <= (LOAD == 4'd0) ? RUN : FLUSH;
            cnt <= LOAD;
          end else if (mem2_dcache_busy) state <= STALL;
        end
        STALL: if (!mem2_dcache_busy) state <= RUN;
        FLUSH: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
